// File: rtl/bbox_sample_sched.sv
// Per-triangle sample scheduler: latches a triangle and its bounding box, then walks
// the box in raster order at subsample pitch, one sample per unhalted cycle.
module bbox_sample_sched #(
  parameter int unsigned SIGFIG = 24,
  parameter int unsigned RADIX  = 10,
  parameter int unsigned VERTS  = 3,
  parameter int unsigned AXIS   = 3,
  parameter int unsigned COLORS = 3,
  parameter int unsigned SS_LG2 = 2
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic                                   halt_RnnnnH,
  input  logic                                   tri_in_valid_H,
  output logic                                   tri_in_ready_H,
  input  logic [VERTS-1:0][AXIS-1:0][SIGFIG-1:0] tri_in_S,
  input  logic [COLORS-1:0][SIGFIG-1:0]          color_in_U,
  input  logic [1:0][SIGFIG-1:0]                 box_ll_S,
  input  logic [1:0][SIGFIG-1:0]                 box_ur_S,
  output logic [VERTS-1:0][AXIS-1:0][SIGFIG-1:0] tri_R16S,
  output logic [COLORS-1:0][SIGFIG-1:0]          color_R16U,
  output logic [1:0][SIGFIG-1:0]                 sample_R16S,
  output logic                                   validSamp_R16H,
  output logic                                   busy_H
);

  localparam int unsigned STEP = 1 << (RADIX - SS_LG2);
  localparam int unsigned EW   = SIGFIG + 1;
  localparam logic [SIGFIG-1:0]    GRID_MASK = ~SIGFIG'(STEP - 1);
  localparam logic signed [EW-1:0] STEP_E    = EW'(STEP);

  typedef enum logic [0:0] {IDLE, WALK} state_t;

  state_t state_q, state_d;

  logic [VERTS-1:0][AXIS-1:0][SIGFIG-1:0] tri_q;
  logic [COLORS-1:0][SIGFIG-1:0]          color_q;
  logic [SIGFIG-1:0] sx_q, sy_q, sx_d, sy_d;
  logic [SIGFIG-1:0] llx_q, urx_q, ury_q;
  logic              valid_q, valid_d, busy_q;
  logic              load;

  logic signed [EW-1:0] nx, ny;
  logic              x_more, last, ready, accept, degen;
  logic [SIGFIG-1:0] in_llx, in_lly;

  // Widen by one bit so compares near the top of the signed range cannot wrap.
  function automatic logic signed [EW-1:0] sext(input logic [SIGFIG-1:0] v);
    return $signed({v[SIGFIG-1], v});
  endfunction

  assign nx     = sext(sx_q) + STEP_E;
  assign ny     = sext(sy_q) + STEP_E;
  assign x_more = nx <= sext(urx_q);
  assign last   = !x_more && (ny > sext(ury_q));
  assign ready  = rst && !halt_RnnnnH && ((state_q == IDLE) || ((state_q == WALK) && last));
  assign accept = tri_in_valid_H && ready;

  assign in_llx = box_ll_S[0] & GRID_MASK;
  assign in_lly = box_ll_S[1] & GRID_MASK;
  assign degen  = (sext(in_llx) > sext(box_ur_S[0])) || (sext(in_lly) > sext(box_ur_S[1]));

  // Next state and next sample position; accept takes priority over the final step.
  always_comb begin
    state_d = state_q;
    sx_d    = sx_q;
    sy_d    = sy_q;
    valid_d = valid_q;
    load    = 1'b0;
    if (!halt_RnnnnH) begin
      if (accept) begin
        load    = 1'b1;
        sx_d    = in_llx;
        sy_d    = in_lly;
        state_d = degen ? IDLE : WALK;
        valid_d = !degen;
      end else begin
        case (state_q)
          WALK: begin
            if (x_more) begin
              sx_d = SIGFIG'(nx);
            end else if (!last) begin
              sx_d = llx_q;
              sy_d = SIGFIG'(ny);
            end else begin
              state_d = IDLE;
              valid_d = 1'b0;
            end
          end
          default: valid_d = 1'b0;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tri_q   <= '0;
      color_q <= '0;
      sx_q    <= '0;
      sy_q    <= '0;
      llx_q   <= '0;
      urx_q   <= '0;
      ury_q   <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      sx_q    <= sx_d;
      sy_q    <= sy_d;
      valid_q <= valid_d;
      busy_q  <= (state_d == WALK);
      if (load) begin
        tri_q   <= tri_in_S;
        color_q <= color_in_U;
        llx_q   <= in_llx;
        urx_q   <= box_ur_S[0];
        ury_q   <= box_ur_S[1];
      end
    end
  end

  assign tri_in_ready_H = ready;
  assign tri_R16S       = tri_q;
  assign color_R16U     = color_q;
  assign sample_R16S    = {sy_q, sx_q};
  assign validSamp_R16H = valid_q;
  assign busy_H         = busy_q;

endmodule

// File: tb/tb_bbox_sample_sched.sv
// Directed bench for bbox_sample_sched: expected samples are queued when a triangle
// is driven and popped as the scheduler presents them.
module tb_bbox_sample_sched;

  localparam int SIGFIG = 24;
  localparam int RADIX  = 10;
  localparam int VERTS  = 3;
  localparam int AXIS   = 3;
  localparam int COLORS = 3;
  localparam int SS_LG2 = 2;
  localparam int SH     = RADIX - SS_LG2;
  localparam int STEP   = 1 << SH;

  typedef logic [VERTS-1:0][AXIS-1:0][SIGFIG-1:0] tri_vec_t;
  typedef logic [COLORS-1:0][SIGFIG-1:0]          col_vec_t;

  typedef struct {
    int x;
    int y;
    int id;
    bit last;
  } exp_t;

  typedef struct {
    int id;
    int llx;
    int lly;
    int urx;
    int ury;
  } desc_t;

  logic clk = 1'b0;
  logic rst;
  logic halt_RnnnnH;
  logic tri_in_valid_H;
  logic tri_in_ready_H;
  tri_vec_t tri_in_S;
  col_vec_t color_in_U;
  logic [1:0][SIGFIG-1:0] box_ll_S, box_ur_S;
  tri_vec_t tri_R16S;
  col_vec_t color_R16U;
  logic [1:0][SIGFIG-1:0] sample_R16S;
  logic validSamp_R16H;
  logic busy_H;

  exp_t  sb[$];
  desc_t pend[$];
  int    n_checks = 0;
  int    n_fail   = 0;

  bbox_sample_sched dut (
    .clk            (clk),
    .rst            (rst),
    .halt_RnnnnH    (halt_RnnnnH),
    .tri_in_valid_H (tri_in_valid_H),
    .tri_in_ready_H (tri_in_ready_H),
    .tri_in_S       (tri_in_S),
    .color_in_U     (color_in_U),
    .box_ll_S       (box_ll_S),
    .box_ur_S       (box_ur_S),
    .tri_R16S       (tri_R16S),
    .color_R16U     (color_R16U),
    .sample_R16S    (sample_R16S),
    .validSamp_R16H (validSamp_R16H),
    .busy_H         (busy_H)
  );

  always #5 clk = ~clk;

  function automatic tri_vec_t tri_of(input int id);
    tri_vec_t t;
    for (int v = 0; v < VERTS; v++)
      for (int a = 0; a < AXIS; a++)
        t[v][a] = SIGFIG'(id * 256 + v * 16 + a);
    return t;
  endfunction

  function automatic col_vec_t color_of(input int id);
    col_vec_t c;
    for (int k = 0; k < COLORS; k++) c[k] = SIGFIG'(id * 4096 + 'h800 + k);
    return c;
  endfunction

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drive a triangle on the input port and queue its expected raster walk.
  task automatic present(input desc_t d);
    int rx, ry, cnt;
    exp_t e;
    tri_in_S       = tri_of(d.id);
    color_in_U     = color_of(d.id);
    box_ll_S       = {SIGFIG'(d.lly), SIGFIG'(d.llx)};
    box_ur_S       = {SIGFIG'(d.ury), SIGFIG'(d.urx)};
    tri_in_valid_H = 1'b1;
    rx  = (d.llx >>> SH) <<< SH;
    ry  = (d.lly >>> SH) <<< SH;
    cnt = 0;
    for (int y = ry; y <= d.ury; y += STEP)
      for (int x = rx; x <= d.urx; x += STEP) begin
        e.x = x; e.y = y; e.id = d.id; e.last = 1'b0;
        sb.push_back(e);
        cnt++;
      end
    if (cnt > 0) begin
      e = sb.pop_back();
      e.last = 1'b1;
      sb.push_back(e);
    end
  endtask

  function automatic desc_t mk(input int id, input int llx, input int lly, input int urx, input int ury);
    desc_t d;
    d.id = id; d.llx = llx; d.lly = lly; d.urx = urx; d.ury = ury;
    return d;
  endfunction

  // Advance one cycle; after an accepting edge present the next pending triangle or drop valid.
  task automatic tick();
    logic acc;
    #1;
    acc = tri_in_valid_H && tri_in_ready_H;
    @(negedge clk);
    if (acc) begin
      if (pend.size() > 0) present(pend.pop_front());
      else tri_in_valid_H = 1'b0;
    end
  endtask

  task automatic expect_samples(input int n, input int halt_at, input int halt_len);
    exp_t e;
    for (int i = 0; i < n; i++) begin
      if (i > 0) tick();
      chk("valid", validSamp_R16H, 1'b1);
      chk("busy", busy_H, 1'b1);
      chk("sb_nonempty", sb.size() != 0, 1'b1);
      if (sb.size() == 0) break;
      e = sb.pop_front();
      chk("sample", sample_R16S, {SIGFIG'(e.y), SIGFIG'(e.x)});
      chk("tri", tri_R16S, tri_of(e.id));
      chk("color", color_R16U, color_of(e.id));
      chk("ready", tri_in_ready_H, e.last);
      if (i == halt_at) begin
        halt_RnnnnH = 1'b1;
        for (int h = 0; h < halt_len; h++) begin
          tick();
          chk("halt_valid", validSamp_R16H, 1'b1);
          chk("halt_sample", sample_R16S, {SIGFIG'(e.y), SIGFIG'(e.x)});
          chk("halt_ready", tri_in_ready_H, 1'b0);
        end
        halt_RnnnnH = 1'b0;
      end
    end
  endtask

  task automatic expect_idle(input string tag);
    chk({tag, "_valid"}, validSamp_R16H, 1'b0);
    chk({tag, "_busy"}, busy_H, 1'b0);
  endtask

  initial begin
    rst            = 1'b1;
    halt_RnnnnH    = 1'b0;
    tri_in_valid_H = 1'b0;
    tri_in_S       = '0;
    color_in_U     = '0;
    box_ll_S       = '0;
    box_ur_S       = '0;
    #2 rst = 1'b0;
    #1;
    expect_idle("rst");
    chk("rst_sample", sample_R16S, 48'd0);
    chk("rst_tri", tri_R16S, 216'd0);
    chk("rst_color", color_R16U, 72'd0);
    chk("rst_ready", tri_in_ready_H, 1'b0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("idle_ready", tri_in_ready_H, 1'b1);
    expect_idle("idle");

    // Basic 5x3 walk
    present(mk(1, 0, 0, 1024, 512));
    tick();
    expect_samples(15, -1, 0);
    tick();
    expect_idle("basic_end");

    // Back-to-back: second triangle waits on the bus for the whole first walk
    pend.push_back(mk(3, 0, 0, 256, 256));
    present(mk(2, 0, 0, 1024, 512));
    tick();
    expect_samples(19, -1, 0);
    tick();
    expect_idle("b2b_end");

    // Halt for three cycles on (512,256)
    present(mk(4, 0, 0, 1024, 512));
    tick();
    expect_samples(15, 7, 3);
    tick();
    expect_idle("halt_end");

    // Degenerate box after grid rounding
    present(mk(5, 600, 0, 500, 512));
    #1;
    chk("degen_ready_pre", tri_in_ready_H, 1'b1);
    tick();
    expect_idle("degen");
    chk("degen_ready_post", tri_in_ready_H, 1'b1);
    chk("degen_sb", sb.size(), 0);

    // Signed box with rounding of ll down to the grid
    present(mk(6, 300, -300, 600, 0));
    tick();
    expect_samples(6, -1, 0);
    tick();
    expect_idle("round_end");

    // Asynchronous reset while (256,256) is presented
    present(mk(7, 0, 0, 1024, 512));
    tick();
    expect_samples(7, -1, 0);
    #2 rst = 1'b0;
    #1;
    expect_idle("arst");
    chk("arst_sample", sample_R16S, 48'd0);
    chk("arst_tri", tri_R16S, 216'd0);
    chk("arst_color", color_R16U, 72'd0);
    chk("arst_ready", tri_in_ready_H, 1'b0);
    tri_in_valid_H = 1'b0;
    sb.delete();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      expect_idle("post_rst");
    end

    // Single-sample box
    present(mk(8, 1024, 1024, 1024, 1024));
    tick();
    expect_samples(1, -1, 0);
    tick();
    expect_idle("single_end");
    chk("final_sb", sb.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
